// File: rtl/pong_pkg.sv
// Shared Pong definitions: match-sequencer state encoding, winner encoding
// and the default start/pause keycodes used by the keyboard consumers.
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SERVE  = 3'd1,
    ST_PLAY   = 3'd2,
    ST_POINT  = 3'd3,
    ST_PAUSED = 3'd4,
    ST_OVER   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    WIN_NONE  = 2'b00,
    WIN_LEFT  = 2'b01,
    WIN_RIGHT = 2'b10
  } winner_t;

  localparam logic [7:0] KEY_START_DEF = 8'h2C;  // space
  localparam logic [7:0] KEY_PAUSE_DEF = 8'h13;  // P

endpackage

// File: rtl/key_press_det.sv
// Keycode edge detector: a press is the frame where keycode first equals
// the key, so a held key yields one event.
// Ports:
//   frame_clk, Reset      clock, synchronous active-high reset
//   keycode[7:0]          current keycode (0 = none)
//   start_press           KEY_START pressed this frame
//   pause_press           KEY_PAUSE pressed this frame
module key_press_det
  import pong_pkg::*;
#(
  parameter logic [7:0] KEY_START = KEY_START_DEF,
  parameter logic [7:0] KEY_PAUSE = KEY_PAUSE_DEF
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  output logic       start_press,
  output logic       pause_press
);

  logic [7:0] keycode_prev;

  always_ff @(posedge frame_clk) begin
    if (Reset) keycode_prev <= 8'h00;
    else       keycode_prev <= keycode;
  end

  assign start_press = (keycode == KEY_START) && (keycode_prev != KEY_START);
  assign pause_press = (keycode == KEY_PAUSE) && (keycode_prev != KEY_PAUSE);

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer. Gates the ball datapath through serve countdowns,
// point displays and pauses, requests recentring, chooses serve direction,
// and keeps the scores and the winner.
// Ports:
//   frame_clk, Reset            clock (one tick per frame), sync active-high reset
//   keycode[7:0]                keyboard keycode bus
//   point_left / point_right    one-frame scoring pulses from the ball datapath
//   ball_run                    ball may move this frame
//   ball_recentre               one-frame request to load the centre position
//   serve_right                 next serve goes toward +X
//   score_left/right[3:0]       scores
//   winner[1:0]                 00 none, 01 left, 10 right
//   state_o[2:0]                current state for on-screen text
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter int         SERVE_DELAY = 60,
  parameter int         POINT_HOLD  = 30,
  parameter int         WIN_SCORE   = 7,
  parameter logic [7:0] KEY_START   = KEY_START_DEF,
  parameter logic [7:0] KEY_PAUSE   = KEY_PAUSE_DEF
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic       point_left,
  input  logic       point_right,
  output logic       ball_run,
  output logic       ball_recentre,
  output logic       serve_right,
  output logic [3:0] score_left,
  output logic [3:0] score_right,
  output logic [1:0] winner,
  output logic [2:0] state_o
);

  // Timer counts down to 0 inclusive, so loading N-1 gives N frames in state.
  localparam logic [7:0] SERVE_LD = 8'(SERVE_DELAY - 1);
  localparam logic [7:0] POINT_LD = 8'(POINT_HOLD - 1);
  localparam logic [3:0] WIN_Q    = 4'(WIN_SCORE);

  state_t     state, state_nxt;
  winner_t    win_q, win_nxt;
  logic [7:0] timer, timer_nxt;
  logic [3:0] sl_nxt, sr_nxt;
  logic       srv_nxt, rec_nxt;
  logic       resume_play, resume_nxt;  // PAUSED returns to PLAY (1) or SERVE (0)
  logic       start_press, pause_press;

  key_press_det #(.KEY_START(KEY_START), .KEY_PAUSE(KEY_PAUSE)) u_keys (
    .frame_clk  (frame_clk),
    .Reset      (Reset),
    .keycode    (keycode),
    .start_press(start_press),
    .pause_press(pause_press)
  );

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state         <= ST_IDLE;
      timer         <= 8'd0;
      score_left    <= 4'd0;
      score_right   <= 4'd0;
      win_q         <= WIN_NONE;
      serve_right   <= 1'b1;
      resume_play   <= 1'b0;
      ball_run      <= 1'b0;
      ball_recentre <= 1'b0;
    end else begin
      state         <= state_nxt;
      timer         <= timer_nxt;
      score_left    <= sl_nxt;
      score_right   <= sr_nxt;
      win_q         <= win_nxt;
      serve_right   <= srv_nxt;
      resume_play   <= resume_nxt;
      // Registered from the next state so it tracks state_o exactly.
      ball_run      <= (state_nxt == ST_PLAY);
      ball_recentre <= rec_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    timer_nxt  = timer;
    sl_nxt     = score_left;
    sr_nxt     = score_right;
    win_nxt    = win_q;
    srv_nxt    = serve_right;
    resume_nxt = resume_play;
    rec_nxt    = 1'b0;
    case (state)
      ST_IDLE, ST_OVER: begin
        if (start_press) begin
          state_nxt = ST_SERVE;
          sl_nxt    = 4'd0;
          sr_nxt    = 4'd0;
          win_nxt   = WIN_NONE;
          srv_nxt   = 1'b1;
          rec_nxt   = 1'b1;
          timer_nxt = SERVE_LD;
        end
      end
      ST_SERVE: begin
        // Pause leaves the timer untouched so the frame it lands on is not lost.
        if (pause_press) begin
          state_nxt  = ST_PAUSED;
          resume_nxt = 1'b0;
        end else if (timer == 8'd0) begin
          state_nxt = ST_PLAY;
        end else begin
          timer_nxt = timer - 8'd1;
        end
      end
      ST_PLAY: begin
        // Points outrank pause; left outranks right.
        if (point_left) begin
          sl_nxt    = score_left + 4'd1;
          srv_nxt   = 1'b0;
          timer_nxt = POINT_LD;
          state_nxt = ST_POINT;
        end else if (point_right) begin
          sr_nxt    = score_right + 4'd1;
          srv_nxt   = 1'b1;
          timer_nxt = POINT_LD;
          state_nxt = ST_POINT;
        end else if (pause_press) begin
          state_nxt  = ST_PAUSED;
          resume_nxt = 1'b1;
        end
      end
      ST_POINT: begin
        if (timer != 8'd0) begin
          timer_nxt = timer - 8'd1;
        end else if (score_left == WIN_Q || score_right == WIN_Q) begin
          state_nxt = ST_OVER;
          win_nxt   = (score_left == WIN_Q) ? WIN_LEFT : WIN_RIGHT;
        end else begin
          state_nxt = ST_SERVE;
          rec_nxt   = 1'b1;
          timer_nxt = SERVE_LD;
        end
      end
      ST_PAUSED: begin
        if (start_press) state_nxt = resume_play ? ST_PLAY : ST_SERVE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign winner  = win_q;
  assign state_o = state;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Bench for pong_match_ctrl: a vector table fed through a scoreboard queue,
// then hand-written multi-cycle sequences for serve/point/pause/win/reset.
module tb_pong_match_ctrl;

  logic       frame_clk = 1'b0;
  logic       Reset;
  logic [7:0] keycode;
  logic       point_left, point_right;
  logic       ball_run, ball_recentre, serve_right;
  logic [3:0] score_left, score_right;
  logic [1:0] winner;
  logic [2:0] state_o;

  int n_chk  = 0;
  int n_pass = 0;

  localparam logic [2:0] S_IDLE = 3'd0, S_SERVE = 3'd1, S_PLAY = 3'd2,
                         S_POINT = 3'd3, S_PAUSED = 3'd4, S_OVER = 3'd5;

  pong_match_ctrl dut (
    .frame_clk    (frame_clk),
    .Reset        (Reset),
    .keycode      (keycode),
    .point_left   (point_left),
    .point_right  (point_right),
    .ball_run     (ball_run),
    .ball_recentre(ball_recentre),
    .serve_right  (serve_right),
    .score_left   (score_left),
    .score_right  (score_right),
    .winner       (winner),
    .state_o      (state_o)
  );

  always #5 frame_clk = ~frame_clk;

  typedef struct {
    logic [7:0] kc;
    logic       pl, pr;
    logic [2:0] st;
    logic       run, rec, srv;
    logic [3:0] sl, sr;
    logic [1:0] win;
  } vec_t;

  vec_t vecs[6];
  vec_t sb[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", nm, act, exp);
  endtask

  // Inputs change #1 after the edge; outputs are sampled at the same point.
  task automatic cyc();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic pulse(input logic pl, input logic pr);
    point_left = pl; point_right = pr;
    cyc();
    point_left = 1'b0; point_right = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] st, input string nm);
    int n = 0;
    while (state_o != st && n < 300) begin cyc(); n++; end
    chk(nm, int'(state_o), int'(st));
  endtask

  task automatic chk_all(input string nm, input vec_t e);
    chk({nm, " state"},  state_o,       e.st);
    chk({nm, " run"},    ball_run,      e.run);
    chk({nm, " rec"},    ball_recentre, e.rec);
    chk({nm, " srv"},    serve_right,   e.srv);
    chk({nm, " sl"},     score_left,    e.sl);
    chk({nm, " sr"},     score_right,   e.sr);
    chk({nm, " win"},    winner,        e.win);
  endtask

  initial begin
    vec_t e;
    Reset = 1'b1; keycode = 8'h00; point_left = 1'b0; point_right = 1'b0;

    //            kc     pl    pr    st       run   rec   srv   sl    sr    win
    vecs[0] = '{8'h00, 1'b0, 1'b0, S_IDLE,  1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 2'd0};
    vecs[1] = '{8'h00, 1'b1, 1'b1, S_IDLE,  1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 2'd0};
    vecs[2] = '{8'h2C, 1'b0, 1'b0, S_SERVE, 1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 2'd0};
    vecs[3] = '{8'h2C, 1'b0, 1'b0, S_SERVE, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 2'd0};
    vecs[4] = '{8'h00, 1'b0, 1'b1, S_SERVE, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 2'd0};
    vecs[5] = '{8'h00, 1'b1, 1'b0, S_SERVE, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 2'd0};

    cyc(); cyc();
    e = '{8'h00, 1'b0, 1'b0, S_IDLE, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 2'd0};
    chk_all("reset", e);
    Reset = 1'b0;

    // Table: idle, ignored points, start, held start, ignored points in SERVE.
    foreach (vecs[i]) begin
      keycode = vecs[i].kc; point_left = vecs[i].pl; point_right = vecs[i].pr;
      sb.push_back(vecs[i]);
      cyc();
      e = sb.pop_front();
      chk_all($sformatf("vec%0d", i), e);
    end
    point_left = 1'b0; point_right = 1'b0;

    // Recentre was seen at t=0 (vec2); vec5 is t=3. Ball runs at t=60.
    repeat (56) cyc();
    chk("serve t59 run", ball_run, 0);
    cyc();
    chk("serve t60 run", ball_run, 1);
    chk("serve t60 state", state_o, S_PLAY);

    // Right scores: 30 POINT frames, then recentre, then 60 serve frames.
    pulse(1'b0, 1'b1);
    chk("pr state", state_o, S_POINT);
    chk("pr score_right", score_right, 1);
    chk("pr serve_right", serve_right, 1);
    chk("pr run", ball_run, 0);
    repeat (29) cyc();
    chk("point u29 rec", ball_recentre, 0);
    chk("point u29 state", state_o, S_POINT);
    cyc();
    chk("point u30 rec", ball_recentre, 1);
    chk("point u30 state", state_o, S_SERVE);
    cyc();
    chk("point u31 rec", ball_recentre, 0);
    repeat (58) cyc();
    chk("reserve run early", ball_run, 0);
    cyc();
    chk("reserve run", ball_run, 1);

    // Both points plus pause together: left wins, right and pause dropped.
    keycode = 8'h13;
    pulse(1'b1, 1'b1);
    keycode = 8'h00;
    chk("both state", state_o, S_POINT);
    chk("both sl", score_left, 1);
    chk("both sr", score_right, 1);
    chk("both srv", serve_right, 0);

    // Left reaches seven.
    for (int i = 2; i <= 7; i++) begin
      wait_state(S_PLAY, $sformatf("to play %0d", i));
      pulse(1'b1, 1'b0);
      chk($sformatf("left score %0d", i), score_left, i);
    end
    repeat (29) cyc();
    chk("win pre state", state_o, S_POINT);
    chk("win pre winner", winner, 0);
    cyc();
    chk("over state", state_o, S_OVER);
    chk("over winner", winner, 1);
    chk("over run", ball_run, 0);
    pulse(1'b1, 1'b1);
    chk("over sl hold", score_left, 7);
    chk("over sr hold", score_right, 1);
    chk("over state hold", state_o, S_OVER);

    // Restart from OVER.
    keycode = 8'h2C;
    cyc();
    e = '{8'h2C, 1'b0, 1'b0, S_SERVE, 1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 2'd0};
    chk_all("restart", e);

    // Pause with 20 serve frames left (timer 19 at t=40), hold P 50 frames.
    keycode = 8'h00;
    repeat (40) cyc();
    keycode = 8'h13;
    cyc();
    chk("paused state", state_o, S_PAUSED);
    repeat (49) cyc();
    chk("held pause state", state_o, S_PAUSED);
    chk("held pause run", ball_run, 0);
    keycode = 8'h2C;
    cyc();
    chk("resume serve", state_o, S_SERVE);
    repeat (19) cyc();
    chk("resume r19 run", ball_run, 0);
    cyc();
    chk("resume r20 run", ball_run, 1);

    // Pause and resume from PLAY.
    keycode = 8'h13;
    cyc();
    chk("play pause", state_o, S_PAUSED);
    chk("play pause run", ball_run, 0);
    keycode = 8'h2C;
    cyc();
    chk("play resume", state_o, S_PLAY);
    chk("play resume run", ball_run, 1);
    keycode = 8'h00;

    // Build 3-5, then reset in POINT.
    for (int i = 0; i < 8; i++) begin
      wait_state(S_PLAY, $sformatf("build %0d", i));
      pulse(i < 3, i >= 3);
    end
    chk("pre reset state", state_o, S_POINT);
    chk("pre reset sl", score_left, 3);
    chk("pre reset sr", score_right, 5);
    Reset = 1'b1;
    point_left = 1'b1;
    cyc();
    Reset = 1'b0;
    point_left = 1'b0;
    e = '{8'h00, 1'b0, 1'b0, S_IDLE, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 2'd0};
    chk_all("mid reset", e);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
